// File: rtl/spy_path_sampler.sv
// Launch/capture controller for the inverter-chain delay sensor: toggles the chain
// input, samples the chain output a fixed number of edges later and counts late arrivals.
module spy_path_sampler #(
   parameter int SAMPLE_DELAY = 1,
   parameter int SETTLE       = 4,
   parameter int WINDOW       = 256,
   parameter int CNT_W        = 16,
   parameter int INVERT       = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   output logic             path_input,
   input  logic             path_result,
   output logic             busy,
   output logic             sample_bit,
   output logic [CNT_W-1:0] fail_count,
   output logic             result_valid,
   input  logic             result_ready
);

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_LAUNCH  = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_SETTLE  = 3'd4;
   localparam logic [2:0] ST_DONE    = 3'd5;

   localparam logic INV = 1'(INVERT);

   logic [2:0]  state;
   logic [7:0]  delayCnt;
   logic [7:0]  settleCnt;
   logic [15:0] launchCnt;
   logic        mismatch;

   assign busy         = (state != ST_IDLE);
   assign result_valid = (state == ST_DONE);
   // path_input already holds the launched value by the time CAPTURE is reached
   assign mismatch     = (path_result != (path_input ^ INV));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         path_input <= 1'b0;
         sample_bit <= 1'b0;
         fail_count <= '0;
         delayCnt   <= '0;
         settleCnt  <= '0;
         launchCnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  fail_count <= '0;
                  launchCnt  <= '0;
                  state      <= ST_LAUNCH;
               end
            end
            ST_LAUNCH: begin
               path_input <= ~path_input;
               delayCnt   <= 8'(SAMPLE_DELAY - 1);
               state      <= (SAMPLE_DELAY == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
               // leaves on the cycle the decrement reaches zero: SAMPLE_DELAY-1 cycles
               delayCnt <= delayCnt - 8'd1;
               if (delayCnt == 8'd1)
                  state <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               sample_bit <= path_result;
               if (mismatch && (fail_count != {CNT_W{1'b1}}))
                  fail_count <= fail_count + 1'b1;
               launchCnt <= launchCnt + 16'd1;
               settleCnt <= 8'(SETTLE - 1);
               state     <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settleCnt == 8'd0)
                  state <= (launchCnt == 16'(WINDOW)) ? ST_DONE : ST_LAUNCH;
               else
                  settleCnt <= settleCnt - 8'd1;
            end
            ST_DONE: begin
               if (result_ready)
                  state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spy_path_sampler.sv
// Randomized bench for spy_path_sampler: a cycle-arithmetic model predicts every launch
// and capture edge; a second instance pins the SAMPLE_DELAY=1 path with literal values.
module tb_spy_path_sampler;

   localparam int SD  = 2;
   localparam int ST  = 3;
   localparam int W   = 12;
   localparam int CW  = 3;
   localparam int INV = 1;
   localparam int P   = SD + 1 + ST;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, rdy = 1'b0;
   logic pin, pres, busy, sbit, rv;
   logic [CW-1:0] fc;

   logic start1 = 1'b0, rdy1 = 1'b0, mode1 = 1'b0, h1 = 1'b0;
   logic pin1, pres1, busy1, sbit1, rv1;
   logic [3:0] fc1;

   int   dly = 0;
   logic cinv = 1'b1, rmode = 1'b0, rbit = 1'b0;
   logic [3:0] hist = '0;

   int nChk = 0, nPass = 0;
   logic chkEn = 1'b0;

   always #5 clk = ~clk;

   spy_path_sampler #(.SAMPLE_DELAY(SD), .SETTLE(ST), .WINDOW(W), .CNT_W(CW), .INVERT(INV)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start), .path_input(pin), .path_result(pres),
      .busy(busy), .sample_bit(sbit), .fail_count(fc), .result_valid(rv), .result_ready(rdy));

   spy_path_sampler #(.SAMPLE_DELAY(1), .SETTLE(4), .WINDOW(4), .CNT_W(4), .INVERT(0)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .path_input(pin1), .path_result(pres1),
      .busy(busy1), .sample_bit(sbit1), .fail_count(fc1), .result_valid(rv1), .result_ready(rdy1));

   // chain models: hist[i] is path_input delayed by i+1 clock edges
   always @(posedge clk) hist <= {hist[2:0], pin};
   always @(posedge clk) h1 <= pin1;

   always_comb begin
      pres = pin ^ cinv;
      if (rmode)        pres = rbit;
      else if (dly > 0) pres = hist[dly-1] ^ cinv;
   end
   assign pres1 = mode1 ? h1 : pin1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChk++;
      if (act !== exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      else nPass++;
   endtask

   // reference model: launch k toggles on edge e0+1+k*P, captures on edge e0+1+k*P+SD
   int   cyc = 0, e0 = 0, rel = 0, k = 0, r = 0, mFail = 0;
   logic mBusy = 1'b0, mValid = 1'b0, mPin = 1'b0, mSample = 1'b0;
   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mBusy = 0; mValid = 0; mPin = 0; mSample = 0; mFail = 0;
      end else begin
         cyc++;
         if (mValid) begin
            if (rdy) begin mValid = 0; mBusy = 0; end
         end else if (!mBusy) begin
            if (start) begin mBusy = 1; mFail = 0; e0 = cyc; end
         end else begin
            rel = cyc - e0;
            if (rel >= 1) begin
               k = (rel - 1) / P;
               r = (rel - 1) % P;
               if (k < W && r == 0) mPin = ~mPin;
               if (k < W && r == SD) begin
                  mSample = pres;
                  if (pres != (mPin ^ 1'(INV)) && mFail < (2**CW - 1)) mFail++;
               end
            end
            if (rel == W * P) mValid = 1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst_n && chkEn) begin
         chk("busy", busy, mBusy);
         chk("result_valid", rv, mValid);
         chk("path_input", pin, mPin);
         chk("sample_bit", sbit, mSample);
         chk("fail_count", fc, mFail);
      end
   end

   task automatic runWin(input int d, input logic ci, input logic rm, input int expFail);
      int n;
      logic [CW-1:0] fcDone;
      dly = d; cinv = ci; rmode = rm;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!rv && n < 2000) begin
         @(negedge clk);
         rbit  = 1'($urandom);
         start = ($urandom_range(0, 7) == 0);
         n++;
      end
      start = 1'b0;
      if (n >= 2000) chk("window timeout", 0, 1);
      if (expFail >= 0) chk("window fail_count", fc, expFail);
      fcDone = fc;
      repeat ($urandom_range(0, 50)) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      chk("valid held", rv, 1);
      chk("count held", fc, fcDone);
      rdy = 1'b1;
      @(negedge clk);
      rdy = 1'b0;
      chk("idle after ready", busy, 0);
      chk("count after ready", fc, fcDone);
   endtask

   initial begin
      int n;
      #1;
      chk("rst path_input", pin, 0);
      chk("rst busy", busy, 0);
      chk("rst valid", rv, 0);
      chk("rst fail_count", fc, 0);
      chk("rst sample_bit", sbit, 0);
      @(negedge clk); #2 rst_n = 1'b1; chkEn = 1'b1;

      runWin(0, 1'b1, 1'b0, 0);   // inverting zero-delay chain matches INVERT=1
      runWin(0, 1'b0, 1'b0, 7);   // wrong polarity: 12 misses saturate at 7
      runWin(1, 1'b1, 1'b0, 0);
      runWin(2, 1'b1, 1'b0, 7);
      runWin(3, 1'b1, 1'b0, 7);
      runWin(0, 1'b0, 1'b1, -1);
      runWin(0, 1'b0, 1'b1, -1);

      // reset asserted in WAIT of launch 5
      dly = 1; cinv = 1'b1; rmode = 1'b0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (1 + 5 * P) @(posedge clk);
      @(negedge clk);
      chk("busy before reset", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst path_input", pin, 0);
      chk("async rst busy", busy, 0);
      chk("async rst valid", rv, 0);
      chk("async rst fail_count", fc, 0);
      chk("async rst sample_bit", sbit, 0);
      @(negedge clk); #2 rst_n = 1'b1;
      runWin(1, 1'b1, 1'b0, 0);
      runWin(0, 1'b0, 1'b1, -1);
      chkEn = 1'b0;

      // SAMPLE_DELAY=1 instance: 4 launches of 6 cycles each
      for (int pass = 0; pass < 2; pass++) begin
         mode1 = 1'(pass);
         @(negedge clk); start1 = 1'b1;
         @(negedge clk); start1 = 1'b0;
         n = 0;
         while (!rv1 && n < 200) begin
            @(negedge clk);
            n++;
            if (!rv1) chk("u1 busy", busy1, 1);
         end
         chk("u1 latency", n, 24);
         chk("u1 fail_count", fc1, (pass == 0) ? 0 : 4);
         rdy1 = 1'b1;
         @(negedge clk);
         rdy1 = 1'b0;
         chk("u1 idle", busy1, 0);
      end

      $display("%0d/%0d checks passed", nPass, nChk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spy_path_sampler.md
Name: spy_path_sampler

Overview:
- Launch/capture controller for the inverter-chain delay sensor.
- Drives the chain input (path_input) with a toggling launch edge and samples the chain output (path_result) a fixed number of cycles later.
- Compares each sample with the expected settled value and counts late-arrival failures over a measurement window.
- Hands the failure count to the readout logic over a valid/ready handshake.

Parameters:
- SAMPLE_DELAY, 1: clock edges from the launch edge to the capture edge; legal range 1..255.
- SETTLE, 4: idle cycles after each capture before the next launch, so the chain can settle fully; legal range 1..255.
- WINDOW, 256: number of launches per measurement; legal range 1..65535.
- CNT_W, 16: width of fail_count.
- INVERT, 0: 1 if the attached chain has an odd number of inverting stages; the expected sample is then the launched value inverted.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle pulse that begins a measurement; accepted only in IDLE
- path_input  out  1  launch register driving the chain input
- path_result  in  1  chain output; sampled directly with no synchronizer, by design
- busy  out  1  high in every state except IDLE
- sample_bit  out  1  last captured path_result value
- fail_count  out  CNT_W  number of mismatches in the current or last window
- result_valid  out  1  fail_count is final
- result_ready  in  1  consumer accepts the result

Behaviour:
- Clocking and reset:
  - One clock: clk. Reset rst_n is asynchronous and active-low.
  - Every register clears immediately when rst_n goes low.
- Reset values: path_input=0, sample_bit=0, fail_count=0, result_valid=0, busy=0, state=IDLE, all internal counters=0.
- States: IDLE, LAUNCH, WAIT, CAPTURE, SETTLE, DONE.
- IDLE:
  - On start=1, clear fail_count and the launch counter, then go to LAUNCH.
  - start in any other state is ignored.
- LAUNCH (1 cycle): path_input toggles on the exiting edge; delay counter loads SAMPLE_DELAY-1; go to WAIT.
- WAIT: decrement the delay counter; when it is 0, go to CAPTURE.
  - With SAMPLE_DELAY=1, WAIT lasts 0 cycles and LAUNCH goes straight to CAPTURE.
  - Net effect: path_result is registered on the SAMPLE_DELAY-th rising edge after the edge that toggled path_input.
- CAPTURE (the capture edge):
  - sample_bit <= path_result.
  - Mismatch when path_result != (path_input ^ INVERT); on a mismatch fail_count increments, saturating at 2^CNT_W-1.
  - The launch counter increments. Go to SETTLE.
- SETTLE: wait SETTLE cycles.
  - If the launch counter == WINDOW, go to DONE.
  - Otherwise go to LAUNCH.
- DONE:
  - result_valid=1; fail_count and sample_bit are held stable.
  - Transfer occurs on a cycle with result_valid=1 and result_ready=1. On the next edge result_valid=0 and state=IDLE; fail_count keeps its value until the next start.
  - If result_ready is low, remain in DONE indefinitely.
- Launch polarity:
  - path_input alternates on every launch, so rising and falling transitions are exercised equally.
  - It is not reset between windows; its value carries across windows.
- Cycle cost: each launch takes 1 + (SAMPLE_DELAY-1) + 1 + SETTLE cycles.
- Reset mid-operation: immediate return to IDLE with reset values; a partial count is discarded.
- Simultaneous start and result_ready in DONE: start is ignored because the state is not IDLE.
- Arithmetic: counters are unsigned; the launch counter is 16 bits; no wrap anywhere (fail_count saturates).

Test Plan:
- Zero-delay chain model (path_result = path_input), SAMPLE_DELAY=1, WINDOW=256, start pulse -> result_valid after 256*(2+4) cycles, fail_count=0, busy high throughout.
- Chain model delaying by 3 cycles, SAMPLE_DELAY=2, WINDOW=10 -> fail_count=10. Repeat with SAMPLE_DELAY=4 -> fail_count=0.
- INVERT=1 with an inverting zero-delay model, WINDOW=8 -> fail_count=0. Same model with INVERT=0 -> fail_count=8. Also check path_input sequence 1,0,1,0,... across launches.
- CNT_W=3, always-mismatch model, WINDOW=20 -> fail_count saturates at 7.
- Hold result_ready=0 for 50 cycles in DONE -> result_valid stays 1 and fail_count is stable. A start pulse during this interval is ignored. Raise result_ready -> IDLE one cycle later.
- Assert rst_n=0 mid-WAIT at launch 5 -> all outputs return to reset values asynchronously. A new start then yields a full-window result.
